lru_tracker: RTL
================

Name: lru_tracker

Overview:
- Replacement-state block for the 4-line fully associative cache.
- Tracks the valid bit and recency age of every line and presents the victim line index, lru_line, to the line-select mux.
- It is the producer end of the victim path: it consumes the selected cacheLine index back as access_line and updates recency from it.
- Hit uses the matched index; miss fills the line this block offered.

Parameters:
- NUM_LINES, 4, number of cache lines; power of two, 2..16.
- IDX_W, 2, line index width; must equal log2(NUM_LINES).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- access_valid  input  1  one access commits this cycle.
- access_line  input  IDX_W  line hit or filled (the mux output cacheLine).
- access_hit  input  1  1 = hit to a valid line, 0 = miss fill into access_line.
- flush  input  1  invalidate all lines and restore reset ages.
- lru_line  output  IDX_W  current victim index.
- victim_valid  output  1  lru_line currently holds valid data (a write-back candidate).
- valid_vec  output  NUM_LINES  per-line valid bits.
- hit_err  output  1  one-cycle pulse: hit reported on an invalid line.

Behaviour:
- State:
  - valid[i], 1 bit per line.
  - age[i], IDX_W bits per line.
  - Ages always form a permutation of 0..NUM_LINES-1: 0 = MRU, NUM_LINES-1 = LRU.
- Reset (rst_n=0 at a clk edge):
  - valid = all 0.
  - age[i] = NUM_LINES-1-i, so line 0 is the LRU.
  - hit_err = 0.
  - Outputs after reset: lru_line=0, victim_valid=0, valid_vec=0.
- Victim select (combinational from registered state; no extra flop):
  - If any line is invalid, lru_line = lowest-index invalid line and victim_valid = 0.
  - Otherwise lru_line = the line with age NUM_LINES-1, and victim_valid = 1.
- Access (access_valid=1, flush=0), with k = access_line and a = age[k]:
  - Every line j with age[j] < a takes age[j]+1.
  - age[k] becomes 0.
  - Lines with age > a are unchanged.
  - This is identical for hit and miss; the permutation is preserved and no wrap occurs.
- Miss: valid[k] is set to 1. k is normally equal to lru_line, but the block does not enforce this.
- Hit with valid[k]=0:
  - hit_err pulses high for the next cycle only.
  - valid[k] is unchanged.
  - The age update still occurs.
- Access to the line that is already MRU (a=0): no age changes.
- Latency:
  - An access at edge N is reflected in lru_line, victim_valid and valid_vec from just after edge N.
  - Back-to-back accesses on consecutive cycles are supported with no bubble.
- flush=1:
  - valid is cleared and ages return to their reset values at the next edge.
  - flush has priority over a simultaneous access; that access is dropped and hit_err does not pulse.
- rst_n=0 overrides flush and access.
- Reset mid-sequence discards all recency; there is no partial state.
- access_valid=0: state holds.
- access_line and access_hit are don't-care when access_valid=0.

Decomposition:
- Shared package cache_pkg holds:
  - NUM_LINES and IDX_W constants.
  - A line-index typedef.
  - The reset-age function (NUM_LINES-1-i).
- One natural sub-module, lru_victim_sel: the purely combinational first-invalid / oldest-age priority select that produces lru_line and victim_valid.
- The age/valid registers and the update logic stay in lru_tracker.

Test Plan:
1. Reset, then idle -> lru_line=0, victim_valid=0, valid_vec=4'b0000, hit_err=0.
2. Four misses filling lines 0,1,2,3 on consecutive cycles -> lru_line steps 1,2,3 and then 0; after the fourth access valid_vec=4'b1111, victim_valid=1 and ages are {3,2,1,0}.
3. From step 2, hits on line 0 then line 2 -> lru_line=1; ages become {1,3,0,2}.
4. Hit on line 3 while valid_vec=4'b0111 -> hit_err high for exactly one cycle; valid_vec stays 4'b0111; line 3 becomes MRU.
5. flush and an access to line 2 in the same cycle with all lines valid -> next cycle valid_vec=0, lru_line=0, ages at reset values, and no trace of the access.
6. Random stream of 1000 accesses against a reference LRU list -> lru_line matches every cycle and the ages remain a permutation.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants and helpers for the 4-line fully associative cache.
package cache_pkg;

    localparam int NUM_LINES = 4;
    localparam int IDX_W     = $clog2(NUM_LINES);

    typedef logic [IDX_W-1:0] line_idx_t;

    // Reset ages make line 0 the LRU and line n-1 the MRU.
    function automatic int reset_age(input int n, input int i);
        return n - 1 - i;
    endfunction

endpackage

// File: rtl/lru_victim_sel.sv
// Victim select: the lowest-index invalid line wins, otherwise the oldest line.
module lru_victim_sel
    import cache_pkg::*;
#(
    parameter int NUM_LINES = cache_pkg::NUM_LINES,
    parameter int IDX_W     = cache_pkg::IDX_W
) (
    input  logic [NUM_LINES-1:0]            valid,
    input  logic [NUM_LINES-1:0][IDX_W-1:0] age,
    output logic [IDX_W-1:0]                lru_line,
    output logic                            victim_valid
);

    logic [IDX_W-1:0] inv_line;
    logic [IDX_W-1:0] old_line;
    logic             any_inv;

    always_comb begin
        inv_line = '0;
        old_line = '0;
        any_inv  = 1'b0;
        // Walk downwards so the last hit is the lowest invalid index.
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                inv_line = IDX_W'(i);
                any_inv  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_LINES; i++) begin
            if (age[i] == IDX_W'(NUM_LINES - 1)) old_line = IDX_W'(i);
        end
    end

    assign lru_line     = any_inv ? inv_line : old_line;
    assign victim_valid = ~any_inv;

endmodule

// File: rtl/lru_tracker.sv
// Replacement state for the fully associative cache: per-line valid and age, victim output.
module lru_tracker
    import cache_pkg::*;
#(
    parameter int NUM_LINES = cache_pkg::NUM_LINES,
    parameter int IDX_W     = cache_pkg::IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 access_valid,
    input  logic [IDX_W-1:0]     access_line,
    input  logic                 access_hit,
    input  logic                 flush,
    output logic [IDX_W-1:0]     lru_line,
    output logic                 victim_valid,
    output logic [NUM_LINES-1:0] valid_vec,
    output logic                 hit_err
);

    logic [NUM_LINES-1:0][IDX_W-1:0] age_q;
    logic [NUM_LINES-1:0][IDX_W-1:0] age_d;
    logic [NUM_LINES-1:0][IDX_W-1:0] age_rst;
    logic [NUM_LINES-1:0]            valid_q;
    logic [IDX_W-1:0]                acc_age;
    logic                            hit_err_q;

    assign acc_age = age_q[access_line];

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_rst
        assign age_rst[g] = IDX_W'(reset_age(NUM_LINES, g));
    end

    // Lines younger than the accessed one age by one; older lines keep their
    // age, so the permutation is preserved without any wrap.
    always_comb begin
        age_d = age_q;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (access_line == IDX_W'(i))
                age_d[i] = '0;
            else if (age_q[i] < acc_age)
                age_d[i] = age_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            age_q     <= age_rst;
            valid_q   <= '0;
            hit_err_q <= 1'b0;
        end else begin
            hit_err_q <= 1'b0;
            if (flush) begin
                age_q   <= age_rst;
                valid_q <= '0;
            end else if (access_valid) begin
                age_q <= age_d;
                if (!access_hit)
                    valid_q[access_line] <= 1'b1;
                hit_err_q <= access_hit & ~valid_q[access_line];
            end
        end
    end

    lru_victim_sel #(
        .NUM_LINES(NUM_LINES),
        .IDX_W    (IDX_W)
    ) u_sel (
        .valid       (valid_q),
        .age         (age_q),
        .lru_line    (lru_line),
        .victim_valid(victim_valid)
    );

    assign valid_vec = valid_q;
    assign hit_err   = hit_err_q;

endmodule
